spike_event_scheduler: RTL and testbench

Arbitrates spike events from two requesters and sequences the synapse-row walk for each granted event. The requesters are external input spikes (host, req/ack) and recurrent spikes (neurons that fired, via an internal FIFO). For each event it issues NR_DEPTH synapse SRAM reads, then the aligned neuron-update write strobes. It sits between the I/O interface and the synapse SRAM / neuron update path inside the network processor.

---
 rtl/spike_event_scheduler_pkg.sv | 32 +++
 rtl/spike_event_scheduler_if.sv | 35 +++
 rtl/spike_event_scheduler_fifo.sv | 58 +++++
 rtl/spike_event_scheduler.sv | 148 ++++++++++++++
 tb/tb_spike_event_scheduler.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_event_scheduler_pkg.sv
// Shared state/grant types and geometry helpers for the spike event scheduler.
package snn_sched_pkg;

    typedef enum logic {IDLE, WALK} sched_state_e;
    typedef enum logic {EXT, REC} grant_e;

    // Number of source rows held in the synapse SRAM.
    function automatic int unsigned num_src(input int unsigned nr_depth,
                                            input int unsigned sr_depth);
        return sr_depth / nr_depth;
    endfunction

    // External sources occupy the low rows; recurrent neurons sit above them.
    function automatic int unsigned n_ext(input int unsigned nr_depth,
                                          input int unsigned sr_depth);
        return num_src(nr_depth, sr_depth) - nr_depth;
    endfunction

    function automatic int unsigned src_width(input int unsigned nr_depth,
                                              input int unsigned sr_depth);
        return $clog2(num_src(nr_depth, sr_depth));
    endfunction

    function automatic int unsigned nr_width(input int unsigned nr_depth);
        return $clog2(nr_depth);
    endfunction

    function automatic int unsigned sr_width(input int unsigned sr_depth);
        return $clog2(sr_depth);
    endfunction

endpackage

// File: rtl/spike_event_scheduler_if.sv
// Spike request and synapse/neuron strobe bundle; master is the scheduler side.
interface spike_sched_if
    import snn_sched_pkg::*;
#(
    parameter int unsigned NR_DEPTH = 16,
    parameter int unsigned SR_DEPTH = 16384
);
    localparam int unsigned SRC_W = src_width(NR_DEPTH, SR_DEPTH);
    localparam int unsigned NR_W  = nr_width(NR_DEPTH);
    localparam int unsigned SR_W  = sr_width(SR_DEPTH);

    logic             input_occurred;
    logic [SRC_W-1:0] input_index;
    logic             input_ack;
    logic             fire_valid;
    logic [NR_W-1:0]  fire_index;
    logic             c_synapse_rd;
    logic [SR_W-1:0]  c_synapse_index;
    logic             c_neuron_we;
    logic [NR_W-1:0]  c_neuron_index;
    logic             c_input;

    modport master (
        input  input_occurred, input_index, fire_valid, fire_index,
        output input_ack, c_synapse_rd, c_synapse_index,
               c_neuron_we, c_neuron_index, c_input
    );

    modport slave (
        output input_occurred, input_index, fire_valid, fire_index,
        input  input_ack, c_synapse_rd, c_synapse_index,
               c_neuron_we, c_neuron_index, c_input
    );

endinterface

// File: rtl/spike_event_scheduler_fifo.sv
// Synchronous FIFO of fired-neuron indices; a pop frees room for a same-cycle push.
module spike_index_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             overflow_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full || do_pop) && !reset;
    assign overflow_o = push_i && full && !do_pop && !reset;
    assign data_o     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spike_event_scheduler.sv
// Arbitrates external and recurrent spikes and walks one synapse row per granted event,
// emitting SRAM reads and latency-aligned neuron update strobes.
module spike_event_scheduler
    import snn_sched_pkg::*;
#(
    parameter int unsigned NR_DEPTH   = 16,
    parameter int unsigned SR_DEPTH   = 16384,
    parameter int unsigned SR_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    spike_sched_if.master bus,
    output logic          busy,
    output logic          fifo_overflow,
    output logic          index_error
);
    localparam int unsigned N_EXT = n_ext(NR_DEPTH, SR_DEPTH);
    localparam int unsigned SRC_W = src_width(NR_DEPTH, SR_DEPTH);
    localparam int unsigned NR_W  = nr_width(NR_DEPTH);
    localparam int unsigned SR_W  = sr_width(SR_DEPTH);

    sched_state_e     state_q, state_d;
    grant_e           last_grant_q, last_grant_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [NR_W-1:0]  n_q, n_d;
    logic             ext_q, ext_d;

    logic             grant_ext;
    logic             grant_rec;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [NR_W-1:0]  fifo_head;
    logic             synapse_rd;

    logic [SR_LATENCY-1:0] dl_vld_q;
    logic [SR_LATENCY-1:0] dl_ext_q;
    logic [NR_W-1:0]       dl_idx_q [SR_LATENCY];

    spike_index_fifo #(
        .WIDTH (NR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (bus.fire_valid),
        .data_i     (bus.fire_index),
        .pop_i      (fifo_pop),
        .data_o     (fifo_head),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    // Grant selection and row walk sequencing.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        src_d         = src_q;
        n_d           = n_q;
        ext_d         = ext_q;
        grant_ext     = 1'b0;
        grant_rec     = 1'b0;
        fifo_pop      = 1'b0;
        bus.input_ack = 1'b0;
        index_error   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !reset) begin
                    grant_ext = bus.input_occurred && (fifo_empty || last_grant_q == REC);
                    grant_rec = !fifo_empty && !grant_ext;
                end
                if (grant_ext) begin
                    bus.input_ack = 1'b1;
                    last_grant_d  = EXT;
                    if (bus.input_index >= SRC_W'(N_EXT)) begin
                        index_error = 1'b1;
                    end else begin
                        src_d   = bus.input_index;
                        ext_d   = 1'b1;
                        n_d     = '0;
                        state_d = WALK;
                    end
                end else if (grant_rec) begin
                    fifo_pop     = 1'b1;
                    last_grant_d = REC;
                    src_d        = SRC_W'(N_EXT) + SRC_W'(fifo_head);
                    ext_d        = 1'b0;
                    n_d          = '0;
                    state_d      = WALK;
                end
            end
            WALK: begin
                n_d = n_q + NR_W'(1);
                if (n_q == NR_W'(NR_DEPTH - 1)) begin
                    n_d     = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= REC;
            src_q        <= '0;
            n_q          <= '0;
            ext_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            n_q          <= n_d;
            ext_q        <= ext_d;
        end
    end

    assign synapse_rd = (state_q == WALK);

    // Delay line aligning neuron strobes with SRAM read data; free-running across walks.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_vld_q <= '0;
            dl_ext_q <= '0;
            for (int i = 0; i < int'(SR_LATENCY); i++) dl_idx_q[i] <= '0;
        end else begin
            dl_vld_q[0] <= synapse_rd;
            dl_ext_q[0] <= synapse_rd & ext_q;
            dl_idx_q[0] <= synapse_rd ? n_q : '0;
            for (int i = 1; i < int'(SR_LATENCY); i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_ext_q[i] <= dl_ext_q[i-1];
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
        end
    end

    assign bus.c_synapse_rd    = synapse_rd;
    assign bus.c_synapse_index = synapse_rd ? SR_W'({src_q, n_q}) : '0;
    assign bus.c_neuron_we     = dl_vld_q[SR_LATENCY-1];
    assign bus.c_neuron_index  = dl_idx_q[SR_LATENCY-1];
    assign bus.c_input         = dl_ext_q[SR_LATENCY-1];
    assign busy                = synapse_rd | (|dl_vld_q);

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed and randomized checks of spike_event_scheduler against a cycle-indexed event model.
module tb_spike_event_scheduler;

    localparam int NR    = 16;
    localparam int LAT   = 1;
    localparam int FD    = 16;
    localparam int N_EXT = 1008;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       req = 1'b0;
    logic [9:0] req_idx = '0;
    logic       fire_v = 1'b0;
    logic [3:0] fire_idx = '0;
    logic       busy, ovf, ierr;

    always #5 clk = ~clk;

    spike_sched_if sif ();

    assign sif.input_occurred = req;
    assign sif.input_index    = req_idx;
    assign sif.fire_valid     = fire_v;
    assign sif.fire_index     = fire_idx;

    spike_event_scheduler dut (
        .clk           (clk),
        .reset         (rst),
        .start         (start),
        .bus           (sif),
        .busy          (busy),
        .fifo_overflow (ovf),
        .index_error   (ierr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: walks are time intervals, strobes are a cycle-keyed schedule.
    bit walking;
    int walk_start;
    int walk_src;
    bit walk_ext;
    bit last_ext;
    int q[$];
    int sched_n[int];
    bit sched_e[int];
    bit ack_seen;

    int c_ack, c_err, c_ovf, c_rd, c_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        walking = 1'b0;
        last_ext = 1'b0;
        q.delete();
        sched_n.delete();
        sched_e.delete();
    endfunction

    function automatic void clr_cnt();
        c_ack = 0; c_err = 0; c_ovf = 0; c_rd = 0; c_we = 0;
    endfunction

    function automatic logic [9:0] pick_idx();
        if ($urandom_range(9) == 0) return 10'($urandom_range(1023, 1008));
        return 10'($urandom_range(1007, 0));
    endfunction

    // Evaluate one cycle with the currently driven inputs, then advance to the next negedge.
    task automatic tick();
        logic [31:0] e_rd, e_sidx, e_we, e_nidx, e_cin, e_busy, e_ack, e_err, e_ovf;
        bit act, g_ext, g_rec;
        int n;
        #1;
        act    = walking && cyc >= walk_start && cyc < walk_start + NR;
        n      = cyc - walk_start;
        e_rd   = 32'(act);
        e_sidx = act ? 32'(walk_src * NR + n) : 32'd0;
        e_we   = 32'(sched_n.exists(cyc));
        e_nidx = sched_n.exists(cyc) ? 32'(sched_n[cyc]) : 32'd0;
        e_cin  = sched_n.exists(cyc) ? 32'(sched_e[cyc]) : 32'd0;
        e_busy = 32'(act || sched_n.num() > 0);
        g_ext = 1'b0;
        g_rec = 1'b0;
        if (!rst && start && !act) begin
            g_ext = req && (q.size() == 0 || !last_ext);
            g_rec = q.size() > 0 && !g_ext;
        end
        e_ack = 32'(g_ext);
        e_err = 32'(g_ext && int'(req_idx) >= N_EXT);
        e_ovf = 32'(!rst && fire_v && q.size() == FD && !g_rec);

        check("synapse_rd",    32'(sif.c_synapse_rd),    e_rd);
        check("synapse_index", 32'(sif.c_synapse_index), e_sidx);
        check("neuron_we",     32'(sif.c_neuron_we),     e_we);
        check("neuron_index",  32'(sif.c_neuron_index),  e_nidx);
        check("c_input",       32'(sif.c_input),         e_cin);
        check("busy",          32'(busy),                e_busy);
        check("input_ack",     32'(sif.input_ack),       e_ack);
        check("index_error",   32'(ierr),                e_err);
        check("fifo_overflow", 32'(ovf),                 e_ovf);

        c_ack += int'(sif.input_ack);
        c_err += int'(ierr);
        c_ovf += int'(ovf);
        c_rd  += int'(sif.c_synapse_rd);
        c_we  += int'(sif.c_neuron_we);
        ack_seen = g_ext;

        if (act) begin
            sched_n[cyc + LAT] = n;
            sched_e[cyc + LAT] = walk_ext;
        end
        if (sched_n.exists(cyc)) begin
            sched_n.delete(cyc);
            sched_e.delete(cyc);
        end
        if (rst) begin
            model_reset();
        end else begin
            if (g_ext) begin
                last_ext = 1'b1;
                if (int'(req_idx) < N_EXT) begin
                    walking = 1'b1; walk_start = cyc + 1;
                    walk_src = int'(req_idx); walk_ext = 1'b1;
                end
            end else if (g_rec) begin
                last_ext = 1'b0;
                walking = 1'b1; walk_start = cyc + 1;
                walk_src = N_EXT + q.pop_front(); walk_ext = 1'b0;
            end
            if (fire_v && !e_ovf[0]) q.push_back(int'(fire_idx));
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; fire_v = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        start = 1'b1;

        // External index 3: reads 48..63, strobes with c_input=1.
        clr_cnt();
        req = 1'b1; req_idx = 10'd3;
        tick();
        req = 1'b0;
        repeat (20) tick();
        check("p1_ack_count", 32'(c_ack), 32'd1);
        check("p1_rd_count",  32'(c_rd),  32'd16);
        check("p1_we_count",  32'(c_we),  32'd16);

        // Recurrent neuron 5 from idle.
        clr_cnt();
        fire_v = 1'b1; fire_idx = 4'd5;
        tick();
        fire_v = 1'b0;
        repeat (20) tick();
        check("p2_rd_count", 32'(c_rd), 32'd16);

        // Tie after reset, then sustained contention.
        do_reset();
        fire_v = 1'b1; fire_idx = 4'd2;
        tick();
        fire_v = 1'b0; req = 1'b1; req_idx = 10'd7;
        for (int i = 0; i < 80; i++) begin
            fire_v = (i % 4 == 0);
            fire_idx = 4'(i % 16);
            tick();
        end
        req = 1'b0; fire_v = 1'b0;
        repeat (40) tick();

        // FIFO fills during a walk; 17th push overflows, then drains in order.
        do_reset();
        clr_cnt();
        req = 1'b1; req_idx = 10'd0; fire_v = 1'b1; fire_idx = 4'd0;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            fire_idx = 4'(k % 16);
            tick();
        end
        fire_v = 1'b0;
        repeat (16 * 17 + 20) tick();
        check("p4_ovf_count", 32'(c_ovf), 32'd1);
        check("p4_rd_count",  32'(c_rd),  32'd272);
        check("p4_we_count",  32'(c_we),  32'd272);

        // Out-of-range index, then start=0 holding a request.
        do_reset();
        clr_cnt();
        req = 1'b1; req_idx = 10'd1010;
        tick();
        req = 1'b0;
        repeat (3) tick();
        check("p5_err_count", 32'(c_err), 32'd1);
        check("p5_rd_count",  32'(c_rd),  32'd0);
        clr_cnt();
        start = 1'b0; req = 1'b1; req_idx = 10'd4;
        repeat (5) tick();
        check("p5_hold_ack", 32'(c_ack), 32'd0);
        start = 1'b1;
        tick();
        req = 1'b0;
        repeat (20) tick();
        check("p5_ack_count", 32'(c_ack), 32'd1);

        // Reset mid-walk at n=7, then a fresh walk.
        req = 1'b1; req_idx = 10'd9;
        tick();
        req = 1'b0;
        repeat (7) tick();
        do_reset();
        tick();
        req = 1'b1; req_idx = 10'd12;
        tick();
        req = 1'b0;
        repeat (20) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(399) == 0);
            start = ($urandom_range(15) != 0);
            if (ack_seen) begin
                if ($urandom_range(3) != 0) req = 1'b0;
                else req_idx = pick_idx();
            end else if (!req && $urandom_range(5) == 0) begin
                req = 1'b1;
                req_idx = pick_idx();
            end
            fire_v = ($urandom_range(2) == 0);
            fire_idx = 4'($urandom_range(15));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
